task_demux_1_2: RTL and testbench
=================================

Name: task_demux_1_2

Overview:
- Buffered 1-to-2 demultiplexer for 4-bit task IDs in the hardware scheduler; the distribution counterpart of the 2:1 task-ID mux.
- Accepts one task-ID stream through a valid/ready handshake.
- Steers each ID to one of two downstream channels, chosen by an explicit select or by internal round-robin.
- Buffers each channel in its own small FIFO so the two consumers drain independently.

Parameters:
- DATA_W, 4, width of task ID.
- DEPTH, 2, entries per channel FIFO. Power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count outputs.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  DATA_W  task ID offered
- in_sel  input  1  target channel (0/1) when auto_mode=0
- auto_mode  input  1  1 = round-robin steering, in_sel ignored
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept this cycle
- out0_data  output  DATA_W  channel 0 head entry
- out0_valid  output  1  channel 0 non-empty
- out0_ready  input  1  channel 0 consumer pops
- out1_data  output  DATA_W  channel 1 head entry
- out1_valid  output  1  channel 1 non-empty
- out1_ready  input  1  channel 1 consumer pops
- out0_count  output  CNT_W  channel 0 occupancy
- out1_count  output  CNT_W  channel 1 occupancy

Behaviour:
- Reset (synchronous, active-high, at the rising edge of clk while rst=1):
  - Clears both FIFO read/write pointers, both counts and rr_ptr.
  - Storage contents are don't-care.
  - After reset: out*_valid=0, out*_data=0, out*_count=0, and rr_ptr=0, so round-robin starts at channel 0.
  - A reset asserted mid-operation discards all buffered IDs. Nothing is popped or pushed on a reset edge.
- Target channel:
  - tgt = rr_ptr when auto_mode=1, else in_sel. Combinational.
- in_ready = !(count[tgt] == DEPTH). Combinational from tgt and the counts.
  - It does not depend on the same-cycle pop (no pass-through when full).
- Push:
  - Occurs when in_valid && in_ready. in_data is written at wr_ptr[tgt], wr_ptr[tgt] increments modulo DEPTH, and count[tgt] increments.
  - When auto_mode=1, rr_ptr toggles on every push. It does not toggle when no push occurs.
  - No skipping: if the round-robin channel is full, in_ready=0 even if the other channel has space.
- Pop, channel k:
  - Occurs when outk_valid && outk_ready. rd_ptr[k] increments modulo DEPTH and count[k] decrements.
  - outk_ready while empty has no effect.
- Simultaneous push and pop on the same channel: both take effect and the count is unchanged.
  - On an empty channel the pop term is 0 (valid=0), so only the push occurs.
- Simultaneous pops on both channels are independent.
- Outputs:
  - outk_valid = (count[k] != 0).
  - outk_data = mem[k][rd_ptr[k]] when valid, forced to 0 when empty.
  - outk_count = count[k]. All are derived from registered state.
- Latency:
  - An ID pushed at edge N is visible on outk_data/outk_valid in the cycle after edge N.
  - Minimum in-to-out latency is 1 cycle. There is no combinational path from in_* to out*_*.
- Ordering: per channel strictly FIFO. No ordering guarantee across channels.
- Wrap-around: pointers wrap at DEPTH. count ranges 0..DEPTH and never exceeds DEPTH.
- Switching auto_mode mid-stream takes effect on the same cycle's tgt. rr_ptr retains its value while auto_mode=0.
- in_data and in_sel are sampled only on push edges. Values while in_valid=0 are ignored.

Test Plan:
- Reset with out*_ready=0, then auto_mode=0, in_sel=0, push 0x3 then 0x7.
  - Required: out0_valid=1 one cycle after the first push, out0_data=0x3, count reaches 2, in_ready=0 while in_sel=0, out1_valid stays 0.
- Channel 0 full (DEPTH=2), in_sel=1, push 0xA.
  - Required: in_ready=1, 0xA accepted, out1_data=0xA next cycle, out1_count=1.
- auto_mode=1, both consumers ready=1, push 0x1,0x2,0x3,0x4 back-to-back.
  - Required: channel 0 emits 0x1,0x3 and channel 1 emits 0x2,0x4, each 1 cycle after its push. in_ready stays 1 and counts never exceed 1.
- Channel 0 full with auto_mode=1 and rr_ptr=0, in_valid=1.
  - Required: in_ready=0 and rr_ptr holds. Pulse out0_ready once: count drops to 1, the next cycle accepts and rr_ptr flips to 1.
- Channel 1 count=1, same-cycle push 0xC and out1_ready=1.
  - Required: old head popped, count stays 1, out1_data=0xC next cycle.
- Fill both channels, then assert rst for 1 cycle with in_valid=1.
  - Required: next cycle all valids=0, data=0, counts=0, no push recorded. The first auto-mode push after reset lands in channel 0.

Source files
------------

// File: rtl/task_demux_1_2.sv
// Buffered 1-to-2 task-ID demultiplexer: one valid/ready input stream steered by
// explicit select or round-robin into two independent per-channel FIFOs.
module task_demux_1_2 #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              auto_mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  out0_count,
    output logic [CNT_W-1:0]  out1_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]         mem_q [2][DEPTH];
    logic [1:0][PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [1:0][PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [1:0][CNT_W-1:0]     count_q, count_d;
    logic                      rr_q, rr_d;
    logic                      tgt;
    logic                      push;
    logic [1:0]                push_ch;
    logic [1:0]                pop;
    logic [1:0]                out_ready;

    assign out_ready = {out1_ready, out0_ready};

    // No skipping: a full target channel stalls input even if the other has room.
    always_comb begin
        tgt      = auto_mode ? rr_q : in_sel;
        in_ready = (count_q[tgt] != CNT_W'(DEPTH));
        push     = in_valid && in_ready;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_ch  = '0;
        pop      = '0;
        rr_d     = rr_q ^ (push & auto_mode);
        for (int unsigned k = 0; k < 2; k++) begin
            push_ch[k]  = push && (tgt == 1'(k));
            pop[k]      = (count_q[k] != '0) && out_ready[k];
            wr_ptr_d[k] = wr_ptr_q[k] + (push_ch[k] ? PTR_W'(1) : '0);
            rd_ptr_d[k] = rd_ptr_q[k] + (pop[k] ? PTR_W'(1) : '0);
            count_d[k]  = count_q[k] + CNT_W'(push_ch[k]) - CNT_W'(pop[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
        end
    end

    // Storage has no reset; writes are suppressed on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[tgt][wr_ptr_q[tgt]] <= in_data;
        end
    end

    assign out0_valid = (count_q[0] != '0);
    assign out1_valid = (count_q[1] != '0);
    assign out0_data  = out0_valid ? mem_q[0][rd_ptr_q[0]] : '0;
    assign out1_data  = out1_valid ? mem_q[1][rd_ptr_q[1]] : '0;
    assign out0_count = count_q[0];
    assign out1_count = count_q[1];

endmodule

// File: tb/tb_task_demux_1_2.sv
// Directed plus short random stimulus for task_demux_1_2, checked against a
// queue-based scoreboard of expected per-channel contents.
module tb_task_demux_1_2;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_sel = 1'b0;
    logic              auto_mode = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out0_data, out1_data;
    logic              out0_valid, out1_valid;
    logic              out0_ready = 1'b0, out1_ready = 1'b0;
    logic [CNT_W-1:0]  out0_count, out1_count;

    task_demux_1_2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .auto_mode(auto_mode), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out0_count(out0_count), .out1_count(out1_count)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    bit                rr_m  = 1'b0;
    bit                known = 1'b0;
    int                checks = 0;
    int                fails  = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the scoreboard, then apply the edge to it.
    task automatic cycle(input string tag);
        bit                t, rdy_e, push_e, pop0, pop1, auto_s, rst_s;
        logic [DATA_W-1:0] d_s;
        #1;
        t      = auto_mode ? rr_m : in_sel;
        rdy_e  = ((t == 1'b0) ? q0.size() : q1.size()) < DEPTH;
        if (known) begin
            check({tag, ".in_ready"}, in_ready, rdy_e);
            check({tag, ".v0"}, out0_valid, q0.size() != 0);
            check({tag, ".v1"}, out1_valid, q1.size() != 0);
            check({tag, ".d0"}, out0_data, (q0.size() != 0) ? q0[0] : '0);
            check({tag, ".d1"}, out1_data, (q1.size() != 0) ? q1[0] : '0);
            check({tag, ".c0"}, out0_count, 8'(q0.size()));
            check({tag, ".c1"}, out1_count, 8'(q1.size()));
        end
        push_e = in_valid && rdy_e;
        pop0   = out0_ready && (q0.size() != 0);
        pop1   = out1_ready && (q1.size() != 0);
        auto_s = auto_mode;
        rst_s  = rst;
        d_s    = in_data;
        @(posedge clk);
        if (rst_s) begin
            q0.delete();
            q1.delete();
            rr_m  = 1'b0;
            known = 1'b1;
        end else if (known) begin
            if (pop0) void'(q0.pop_front());
            if (pop1) void'(q1.pop_front());
            if (push_e) begin
                if (t == 1'b0) q0.push_back(d_s);
                else           q1.push_back(d_s);
                if (auto_s) rr_m = ~rr_m;
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit s,
                         input bit a, input bit r0, input bit r1);
        in_valid = v; in_data = d; in_sel = s; auto_mode = a;
        out0_ready = r0; out1_ready = r1;
    endtask

    initial begin
        // Reset, then manual pushes into channel 0 until full.
        rst = 1'b1; drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("rst0"); cycle("rst1");
        rst = 1'b0;
        check("post_rst.c0", out0_count, 8'h0);
        drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0); cycle("man_p3");
        check("first_push.v0", out0_valid, 1'b1);
        check("first_push.d0", out0_data, 8'h3);
        drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0); cycle("man_p7");
        drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0); cycle("full0_stall");
        check("full0.in_ready", in_ready, 1'b0);
        drive(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0); cycle("sel1_pA");
        check("sel1.d1", out1_data, 8'hA);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0); cycle("idle0");

        // Drain, then round-robin with both consumers always ready.
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("drain0"); cycle("drain1"); cycle("drain2");
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b1, 1'b1, 1'b1); cycle("rr_stream");
        end
        drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1); cycle("rr_tail0"); cycle("rr_tail1");

        // Fill both channels in auto mode, free channel 1, stall on full channel 0.
        drive(1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0); cycle("fill5");
        drive(1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0); cycle("fill6");
        drive(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0); cycle("fill8");
        drive(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0); cycle("fill9");
        drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1); cycle("free1a"); cycle("free1b");
        drive(1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0); cycle("noskip0"); cycle("noskip1");
        check("noskip.in_ready", in_ready, 1'b0);
        drive(1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0); cycle("pulse_pop0");
        drive(1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0); cycle("accept_B");
        check("accept_B.c0", out0_count, 8'h2);
        drive(1'b1, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0); cycle("rr_to_ch1");
        check("rr_to_ch1.d1", out1_data, 8'hD);

        // Same-cycle push and pop on channel 1.
        drive(1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 1'b1); cycle("pushpop1");
        check("pushpop1.c1", out1_count, 8'h1);
        check("pushpop1.d1", out1_data, 8'hC);
        drive(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0); cycle("fill_E");

        // Reset with both channels full and a push offered.
        rst = 1'b1; drive(1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0); cycle("rst_mid");
        rst = 1'b0; drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0); cycle("after_rst");
        check("after_rst.c1", out1_count, 8'h0);
        drive(1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0); cycle("auto_after_rst");
        check("auto_after_rst.d0", out0_data, 8'hF);
        drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0); cycle("idle1");

        // Short random mix, scoreboard still checking every cycle.
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
